// File: rtl/imem_boot_responder.sv
// Boots a program from a byte stream into word storage while holding the CPU in reset, then
// serves combinational instruction fetches. Define IMEM_CSUM_EN to append and verify a checksum byte.
module imem_boot_responder #(
  parameter int unsigned AW  = 8,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  input  logic [31:0] IR_addr,
  output logic [31:0] IR,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_err,
  output logic        fetch_err
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {LOAD, CHECK, RUN, ERR} state_e;

  state_e        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] word_cnt, word_cnt_nxt;
  logic [1:0]    byte_cnt, byte_cnt_nxt;
  logic [23:0]   word_buf, word_buf_nxt;
  logic          load_err_nxt, fetch_err_nxt;
  logic          wr_en;
  logic [31:0]   wr_data, cur_word;
  logic [31:0]   mem [DEPTH];

  logic          accept_c, full_c;
  logic [AW-1:0] idx_c;
  logic          aligned_c, in_range_c, hit_c, fetch_bad_c;

  assign accept_c = ld_valid & ld_ready & (state == LOAD);
  assign full_c   = (word_cnt == CW'(DEPTH));

  // Fetch path: only live once the CPU is out of reset
  assign idx_c       = IR_addr[AW+1:2];
  assign aligned_c   = (IR_addr[1:0] == 2'b00);
  assign in_range_c  = (IR_addr[31:AW+2] == '0);
  assign hit_c       = cpu_rst_n & aligned_c & in_range_c & ({1'b0, idx_c} < word_cnt);
  assign fetch_bad_c = cpu_rst_n & ~(aligned_c & in_range_c);
  assign IR          = hit_c ? mem[idx_c] : NOP;

  // Word formed by the incoming byte on top of the buffered ones, zero-padded on the right
  always_comb begin
    case (byte_cnt)
      2'd0:    cur_word = {ld_byte, 24'h0};
      2'd1:    cur_word = {word_buf[7:0], ld_byte, 16'h0};
      2'd2:    cur_word = {word_buf[15:0], ld_byte, 8'h0};
      default: cur_word = {word_buf, ld_byte};
    endcase
  end

`ifdef IMEM_CSUM_EN
  logic [7:0]  sum, sum_nxt, csum_tot_c;
  logic [31:0] pad_word;

  assign csum_tot_c = sum + ld_byte;

  // Flush of buffered program bytes when the checksum byte arrives mid-word
  always_comb begin
    case (byte_cnt)
      2'd1:    pad_word = {word_buf[7:0], 24'h0};
      2'd2:    pad_word = {word_buf[15:0], 16'h0};
      default: pad_word = {word_buf, 8'h0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else        sum <= sum_nxt;
  end
`endif

  // Next-state and load datapath
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    word_cnt_nxt  = word_cnt;
    byte_cnt_nxt  = byte_cnt;
    word_buf_nxt  = word_buf;
    load_err_nxt  = load_err;
    fetch_err_nxt = fetch_err | fetch_bad_c;
    wr_en         = 1'b0;
    wr_data       = cur_word;
`ifdef IMEM_CSUM_EN
    sum_nxt       = sum;
`endif
    case (state)
      LOAD: begin
        if (accept_c) begin
`ifdef IMEM_CSUM_EN
          if (ld_last) begin
            wr_en   = (byte_cnt != 2'd0);
            wr_data = pad_word;
            if (load_err || (csum_tot_c != 8'h00)) begin
              state_nxt    = ERR;
              load_err_nxt = 1'b1;
            end else begin
              state_nxt = CHECK;
            end
          end else if (full_c) begin
            load_err_nxt = 1'b1;
          end else begin
            sum_nxt      = csum_tot_c;
            word_buf_nxt = {word_buf[15:0], ld_byte};
            byte_cnt_nxt = byte_cnt + 2'd1;
            wr_en        = (byte_cnt == 2'd3);
          end
`else
          if (full_c) begin
            load_err_nxt = 1'b1;
          end else begin
            word_buf_nxt = {word_buf[15:0], ld_byte};
            byte_cnt_nxt = byte_cnt + 2'd1;
            wr_en        = (byte_cnt == 2'd3) | ld_last;
          end
          if (ld_last) state_nxt = RUN;
`endif
        end
      end
      CHECK:   state_nxt = RUN;
      default: ;
    endcase
    if (wr_en) begin
      wr_ptr_nxt   = wr_ptr + AW'(1);
      word_cnt_nxt = word_cnt + CW'(1);
      byte_cnt_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      ld_ready  <= 1'b0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      word_cnt  <= word_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      word_buf  <= word_buf_nxt;
      ld_ready  <= (state_nxt == LOAD);
      load_done <= (state_nxt == RUN);
      // Lags load_done by one cycle so every word is valid before the first fetch
      cpu_rst_n <= (state == RUN);
      load_err  <= load_err_nxt;
      fetch_err <= fetch_err_nxt;
    end
  end

  // Storage is deliberately not reset; word_cnt hides stale contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_imem_boot_responder.sv
// Self-checking bench for imem_boot_responder: directed boot/fetch scenarios plus randomized
// programs and fetch addresses checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_imem_boot_responder;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CAP   = 4 * DEPTH;
  localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IMEM_CSUM_EN
  localparam bit CSUM_TAIL = 1'b1;
`else
  localparam bit CSUM_TAIL = 1'b0;
`endif

  logic        clk, rst_n, ld_valid, ld_ready, ld_last;
  logic [7:0]  ld_byte;
  logic [31:0] IR_addr, IR;
  logic        cpu_rst_n, load_done, load_err, fetch_err;

  imem_boot_responder #(.AW(AW), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .IR_addr(IR_addr), .IR(IR),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] exp_mem [DEPTH];
  int          exp_cnt;
  bit          exp_ferr;
  bit          exp_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Expected storage: bytes packed big-endian, capped at capacity, last word zero-padded
  task automatic build_model(input logic [7:0] prog[$]);
    int stored;
    logic [31:0] word;
    int k;
    stored  = (prog.size() > CAP) ? int'(CAP) : prog.size();
    exp_cnt = (stored + 3) / 4;
    for (int w = 0; w < exp_cnt; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        k    = 4 * w + b;
        word = word << 8;
        if (k < stored) word[7:0] = prog[k];
      end
      exp_mem[w] = word;
    end
  endtask

  function automatic logic [31:0] exp_ir(input logic [31:0] a);
    if (!exp_run || a[1:0] != 2'b00 || a >= CAP) return NOP;
    if (int'(a >> 2) < exp_cnt) return exp_mem[a >> 2];
    return NOP;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_IR", IR, NOP);
    exp_run  = 1'b0;
    exp_ferr = 1'b0;
    exp_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ld_ready_after_rst", 32'(ld_ready), 32'd1);
  endtask

  task automatic stream(input logic [7:0] bytes[$], input bit last, input bit csum_tail);
    for (int i = 0; i < bytes.size(); i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_byte  = bytes[i];
      ld_last  = last && (i == bytes.size() - 1);
      for (int k = 0; k < 8 && ld_ready !== 1'b1; k++) @(negedge clk);
      check("ld_ready", 32'(ld_ready), 32'd1);
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (!(csum_tail && i == bytes.size() - 1))
        check($sformatf("load_err_b%0d", i + 1), 32'(load_err), 32'((i + 1) > CAP));
    end
  endtask

  task automatic load_program(input logic [7:0] prog[$], input bit bad_csum);
    logic [7:0] st[$];
    bit         exp_lerr;
    build_model(prog);
    st       = prog;
    exp_lerr = (prog.size() > CAP);
`ifdef IMEM_CSUM_EN
    begin
      logic [7:0] s;
      s = 8'h00;
      foreach (prog[i]) s = s + prog[i];
      s = ~s + 8'd1;
      st.push_back(bad_csum ? s + 8'd1 : s);
      exp_lerr = exp_lerr || bad_csum;
    end
`endif
    stream(st, 1'b1, CSUM_TAIL);
    check("ld_ready_done", 32'(ld_ready), 32'd0);
    check("load_err_final", 32'(load_err), 32'(exp_lerr));
`ifdef IMEM_CSUM_EN
    if (exp_lerr) begin
      repeat (20) @(posedge clk);
      #1;
      check("err_cpu_held", 32'(cpu_rst_n), 32'd0);
      check("err_no_done", 32'(load_done), 32'd0);
      check("err_no_ready", 32'(ld_ready), 32'd0);
      return;
    end
    check("check_state_no_done", 32'(load_done), 32'd0);
    @(posedge clk);
    #1;
`else
    if (bad_csum) $display("note: checksum variant ignored in this build");
`endif
    check("load_done", 32'(load_done), 32'd1);
    check("cpu_rst_n_held", 32'(cpu_rst_n), 32'd0);
    @(posedge clk);
    #1;
    check("cpu_rst_n_release", 32'(cpu_rst_n), 32'd1);
    exp_run = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    IR_addr = a;
    #1;
    check($sformatf("IR@%h", a), IR, exp_ir(a));
    if (exp_run && (a[1:0] != 2'b00 || a >= CAP)) exp_ferr = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("fetch_err@%h", a), 32'(fetch_err), 32'(exp_ferr));
    IR_addr = '0;
  endtask

  logic [7:0]  q[$];
  logic [31:0] a;
  int          len;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_byte  = '0;
    IR_addr  = '0;
    exp_run  = 1'b0;
    exp_ferr = 1'b0;
    exp_cnt  = 0;

    // Two full words, then in-range and beyond-count fetches
    do_reset();
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    load_program(q, 1'b0);
    fetch(32'h4);
    fetch(32'h0);
    fetch(32'h8);

    // Loader traffic while running is ignored
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = 8'hFF; ld_last = 1'b1;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    check("run_ignore_ready", 32'(ld_ready), 32'd0);
    check("run_ignore_err", 32'(load_err), 32'd0);
    fetch(32'h4);

    // Misaligned and out-of-range fetches flag a sticky error
    fetch(32'h2);
    fetch(32'h400);

    // Partial last word is zero-padded
    do_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_program(q, 1'b0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'h0);

    // Reset mid-load, reload one word: stale second word stays hidden
    do_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    stream(q, 1'b0, 1'b0);
    do_reset();
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_program(q, 1'b0);
    fetch(32'h4);
    fetch(32'h0);

`ifdef IMEM_CSUM_EN
    do_reset();
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_program(q, 1'b0);
    fetch(32'h0);
    do_reset();
    load_program(q, 1'b1);
`endif

    // Randomized programs and fetch addresses
    for (int it = 0; it < 6; it++) begin
      do_reset();
      len = int'($urandom_range(1, 48));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
      load_program(q, 1'b0);
      for (int f = 0; f < 10; f++) begin
        case ($urandom_range(0, 3))
          0: a = 32'($urandom_range(0, exp_cnt - 1)) << 2;
          1: a = 32'($urandom_range(exp_cnt, DEPTH - 1)) << 2;
          2: a = (32'($urandom_range(0, CAP - 1)) & ~32'h3) | 32'($urandom_range(1, 3));
          default: a = 32'(CAP) + (32'($urandom_range(0, 65535)) << 2);
        endcase
        fetch(a);
      end
    end

    // Exactly full storage: no overflow
    do_reset();
    q.delete();
    for (int i = 0; i < int'(CAP); i++) q.push_back(8'($urandom_range(0, 255)));
    load_program(q, 1'b0);
    fetch(32'h0);
    fetch(32'(CAP - 4));

    // Overflow: extra bytes discarded, load_err raised from the first excess byte
    do_reset();
    q.delete();
    for (int i = 0; i < int'(CAP) + 6; i++) q.push_back(8'($urandom_range(0, 255)));
    load_program(q, 1'b0);
    fetch(32'h0);
    fetch(32'h1F0);
    fetch(32'(CAP - 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
